// File: rtl/binary_game_pkg.sv
// Shared definitions for the binary guessing game: round states, LFSR constants
// and the score width used by both the round controller and the score logic.
package binary_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        DONE = 2'd3
    } game_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int         SCORE_W   = 4;

    // Galois step for x^8+x^6+x^5+x^4+1; a nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        logic [7:0] nxt;
        nxt = {1'b0, cur[7:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR supplying pseudo-random round targets.
module lfsr8
    import binary_game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    // Advance one step every cycle regardless of game state.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/round_judge.sv
// Round controller: target selection, answer checking, countdown and game-over decision.
// Optional build macro ROUND_JUDGE_MISS_PENALTY_EN deducts PENALTY_SEC per wrong answer.
module round_judge
    import binary_game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int GAME_SECONDS  = 60,
    parameter int WIN_COUNT     = 15,
    parameter int PENALTY_SEC   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] switches,
    output logic [7:0] target,
    output logic       is_equal,
    output logic       game_end,
    output logic [5:0] time_left
);

    localparam int                  TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0]   TICK_MAX  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]          TIME_INIT = 6'(GAME_SECONDS);
    localparam logic [SCORE_W-1:0]  HIT_GOAL  = SCORE_W'(WIN_COUNT);
    localparam logic [6:0]          PENALTY   = 7'(PENALTY_SEC);
`ifdef ROUND_JUDGE_MISS_PENALTY_EN
    localparam logic                MISS_PENALTY_EN = 1'b1;
`else
    localparam logic                MISS_PENALTY_EN = 1'b0;
`endif

    game_state_t         state_r, state_s;
    logic [7:0]          lfsr_s;
    logic [7:0]          target_r, target_s;
    logic                is_equal_r, is_equal_s;
    logic [5:0]          time_r, time_s;
    logic [SCORE_W-1:0]  hit_r, hit_s, hit_inc_s;
    logic [TICK_W-1:0]   tick_r, tick_s;
    logic                submit_q_r;
    logic                done_r;
    logic                sub_ev_s, match_s, wrap_s, timeout_s;
    logic [6:0]          drop_s;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_s)
    );

    assign sub_ev_s  = submit & ~submit_q_r;
    assign match_s   = (switches == target_r);
    assign wrap_s    = (tick_r == TICK_MAX);
    // Only a tick that lands on the last second is a timeout; it beats any submit.
    assign timeout_s = wrap_s & (time_r <= 6'd1);
    assign hit_inc_s = hit_r + 1'b1;
    assign drop_s    = PENALTY + {6'd0, wrap_s};

    // Next-state and datapath decisions for the round FSM.
    always_comb begin
        state_s    = state_r;
        target_s   = target_r;
        is_equal_s = 1'b0;
        time_s     = time_r;
        hit_s      = hit_r;
        tick_s     = tick_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    target_s = lfsr_s;
                    tick_s   = '0;
                    state_s  = PLAY;
                end else begin
                    state_s  = IDLE;
                end
            end
            PLAY: begin
                if (wrap_s) begin
                    tick_s = '0;
                end else begin
                    tick_s = tick_r + 1'b1;
                end
                if (timeout_s) begin
                    time_s  = 6'd0;
                    state_s = DONE;
                end else if (sub_ev_s && match_s) begin
                    is_equal_s = 1'b1;
                    hit_s      = hit_inc_s;
                    target_s   = lfsr_s;
                    time_s     = time_r - {5'd0, wrap_s};
                    if (hit_inc_s == HIT_GOAL) begin
                        state_s = WIN;
                    end else begin
                        state_s = PLAY;
                    end
                end else if (sub_ev_s && (MISS_PENALTY_EN == 1'b1)) begin
                    if ({1'b0, time_r} <= drop_s) begin
                        time_s  = 6'd0;
                        state_s = DONE;
                    end else begin
                        time_s  = 6'({1'b0, time_r} - drop_s);
                    end
                end else begin
                    time_s = time_r - {5'd0, wrap_s};
                end
            end
            // One-cycle stop so the final is_equal pulse precedes game_end.
            WIN: begin
                state_s = DONE;
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            target_r   <= 8'h00;
            is_equal_r <= 1'b0;
            time_r     <= TIME_INIT;
            hit_r      <= '0;
            tick_r     <= '0;
            submit_q_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            target_r   <= target_s;
            is_equal_r <= is_equal_s;
            time_r     <= time_s;
            hit_r      <= hit_s;
            tick_r     <= tick_s;
            submit_q_r <= submit;
            done_r     <= (state_s == DONE);
        end
    end

    assign target    = target_r;
    assign is_equal  = is_equal_r;
    assign time_left = time_r;
    // Masked by rst so sinks that prioritise game_end over rst still clear.
    assign game_end  = done_r & ~rst;

endmodule

// File: tb/tb_round_judge.sv
// Randomized self-checking bench for round_judge against a rule-level reference model.
// Define ROUND_JUDGE_MISS_PENALTY_EN for both RTL and bench to exercise the penalty build.
module tb_round_judge;

    localparam int T  = 4;
    localparam int GS = 3;
    localparam int W  = 2;
    localparam int P  = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       submit;
    logic [7:0] switches;
    logic [7:0] target;
    logic       is_equal;
    logic       game_end;
    logic [5:0] time_left;

    round_judge #(
        .TICKS_PER_SEC (T),
        .GAME_SECONDS  (GS),
        .WIN_COUNT     (W),
        .PENALTY_SEC   (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .submit    (submit),
        .switches  (switches),
        .target    (target),
        .is_equal  (is_equal),
        .game_end  (game_end),
        .time_left (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 playing, 2 won (one cycle), 3 over.
    logic [7:0] seq [0:254];
    int         m_age;
    int         m_phase;
    logic [7:0] m_target;
    bit         m_eq;
    int         m_secs;
    int         m_hits;
    int         m_pc;
    bit         m_subq;
    int         hold_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build_seq();
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        end
    endtask

    function automatic logic [7:0] cur_lfsr();
        return seq[m_age % 255];
    endfunction

    task automatic model_step();
        bit ev;
        int s;
        ev = submit && !m_subq;
        if (rst) begin
            m_phase = 0; m_target = 8'h00; m_eq = 1'b0; m_secs = GS;
            m_hits = 0; m_pc = 0; m_subq = 1'b0; m_age = 0;
        end else begin
            m_eq = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_target = cur_lfsr();
                    m_pc = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_pc++;
                s = m_secs - (((m_pc % T) == 0) ? 1 : 0);
                if (s == 0) begin
                    m_secs = 0;
                    m_phase = 3;
                end else if (ev && switches == m_target) begin
                    m_eq = 1'b1;
                    m_hits++;
                    m_target = cur_lfsr();
                    m_secs = s;
                    if (m_hits == W) m_phase = 2;
                end
`ifdef ROUND_JUDGE_MISS_PENALTY_EN
                else if (ev) begin
                    s = s - P;
                    if (s <= 0) begin
                        m_secs = 0;
                        m_phase = 3;
                    end else begin
                        m_secs = s;
                    end
                end
`endif
                else begin
                    m_secs = s;
                end
            end else if (m_phase == 2) begin
                m_phase = 3;
            end
            m_subq = submit;
            m_age++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("target", 32'(target), 32'(m_target));
        check("is_equal", 32'(is_equal), 32'(m_eq));
        check("time_left", 32'(time_left), 32'(m_secs));
        check("game_end", 32'(game_end), 32'(m_phase == 3 && !rst));
    endtask

    // Choose the next submit/switches values according to a game strategy.
    task automatic drive(input int strat);
        if (submit) begin
            hold_left--;
            if (hold_left <= 0) submit = 1'b0;
        end else if (strat == 1) begin
            if ($urandom_range(0, 2) == 0) begin
                switches  = ($urandom_range(0, 1) == 1) ? m_target : 8'($urandom);
                submit    = 1'b1;
                hold_left = $urandom_range(1, 5);
            end
        end else if (strat == 2) begin
            switches  = m_target;
            submit    = 1'b1;
            hold_left = $urandom_range(1, 5);
        end else if (strat == 3) begin
            if (m_phase == 1 && m_secs == 1 && ((m_pc + 1) % T) == 0) begin
                switches  = m_target;
                submit    = 1'b1;
                hold_left = 1;
            end
        end
    endtask

    initial begin
        int  strat;
        int  n;
        bit  abort;
        build_seq();
        rst = 1'b1; start = 1'b0; submit = 1'b0; switches = 8'h00; hold_left = 0;
        m_age = 0; m_phase = 0; m_target = 8'h00; m_eq = 1'b0; m_secs = GS;
        m_hits = 0; m_pc = 0; m_subq = 1'b0;
        for (int g = 0; g < 60; g++) begin
            strat = g % 4;
            rst = 1'b1; start = 1'b0; submit = 1'b0; hold_left = 0;
            #1;
            if (g > 0) check("game_end_in_rst", 32'(game_end), 32'd0);
            cycle();
            if ($urandom_range(0, 1) == 1) cycle();
            rst = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                drive(strat == 0 ? 0 : 1);
                cycle();
            end
            start = 1'b1;
            cycle();
            if ($urandom_range(0, 1) == 1) cycle();
            start = 1'b0;
            n = 0;
            abort = 1'b0;
            while (m_phase != 3 && n < 200 && !abort) begin
                drive(strat);
                if (strat == 1 && $urandom_range(0, 79) == 0) begin
                    abort = 1'b1;
                end else begin
                    cycle();
                    n++;
                end
            end
            if (n >= 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL game_bound: game %0d still running after %0d cycles, required end", g, n);
            end
            if (!abort) begin
                repeat (3) begin
                    drive(1);
                    start = 1'($urandom_range(0, 1));
                    cycle();
                end
                start = 1'b0;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
